hwpe_ctrl_periph_mux_rr: RTL and testbench

//  N-master to 1-slave multiplexer for the HWPE peripheral control bus (req/gnt, add, we_n, be, data, id; r_data/r_valid/r_id).

---
 rtl/hwpe_ctrl_periph_mux_rr.sv | 182 ++++++++++++++++++
 tb/tb_hwpe_ctrl_periph_mux_rr.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_periph_mux_rr.sv
// N-to-1 HWPE peripheral control bus multiplexer: round-robin arbitration with grant
// locking, master-index ID tagging, outstanding-transaction cap, optional response register.
module hwpe_ctrl_periph_mux_rr #(
  parameter int N_MASTERS       = 2,
  parameter int ID_WIDTH        = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_REG        = 0,
  localparam int IDX_W          = $clog2(N_MASTERS),
  localparam int BE_WIDTH       = DATA_WIDTH / 8,
  localparam int SID_WIDTH      = ID_WIDTH + IDX_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_MASTERS-1:0]             m_req_i,
  output logic [N_MASTERS-1:0]             m_gnt_o,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_add_i,
  input  logic [N_MASTERS-1:0]             m_we_n_i,
  input  logic [N_MASTERS*BE_WIDTH-1:0]    m_be_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_data_i,
  input  logic [N_MASTERS*ID_WIDTH-1:0]    m_id_i,
  output logic [N_MASTERS*DATA_WIDTH-1:0]  m_r_data_o,
  output logic [N_MASTERS-1:0]             m_r_valid_o,
  output logic [N_MASTERS*ID_WIDTH-1:0]    m_r_id_o,
  output logic                             s_req_o,
  input  logic                             s_gnt_i,
  output logic [ADDR_WIDTH-1:0]            s_add_o,
  output logic                             s_we_n_o,
  output logic [BE_WIDTH-1:0]              s_be_o,
  output logic [DATA_WIDTH-1:0]            s_data_o,
  output logic [SID_WIDTH-1:0]             s_id_o,
  input  logic [DATA_WIDTH-1:0]            s_r_data_i,
  input  logic                             s_r_valid_i,
  input  logic [SID_WIDTH-1:0]             s_r_id_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             locked_q, locked_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand_idx;
  logic             lock_hold;
  logic             found;
  logic             s_req;
  logic             handshake;
  logic             resp_dec;
  int               cand;

  logic [ADDR_WIDTH-1:0] add_arr  [N_MASTERS];
  logic [BE_WIDTH-1:0]   be_arr   [N_MASTERS];
  logic [DATA_WIDTH-1:0] data_arr [N_MASTERS];
  logic [ID_WIDTH-1:0]   id_arr   [N_MASTERS];

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
    assign add_arr[gi]  = m_add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign be_arr[gi]   = m_be_i[gi*BE_WIDTH +: BE_WIDTH];
    assign data_arr[gi] = m_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign id_arr[gi]   = m_id_i[gi*ID_WIDTH +: ID_WIDTH];
  end

  // A lock only holds while its owner keeps requesting; a dropped request frees the bus.
  always_comb begin
    lock_hold = locked_q & m_req_i[lock_idx_q];
    winner    = rr_ptr_q;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    if (lock_hold) begin
      winner = lock_idx_q;
    end else begin
      for (int k = 0; k < N_MASTERS; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= N_MASTERS) cand = cand - N_MASTERS;
        cand_idx = IDX_W'(cand);
        if (!found && m_req_i[cand_idx]) begin
          found  = 1'b1;
          winner = cand_idx;
        end
      end
    end
  end

  assign s_req     = (|m_req_i) & (cnt_q < MAX_CNT) & ~rst_i;
  assign handshake = s_req & s_gnt_i;
  assign resp_dec  = s_r_valid_i & (cnt_q != '0);

  assign s_req_o  = s_req;
  assign s_add_o  = add_arr[winner];
  assign s_we_n_o = m_we_n_i[winner];
  assign s_be_o   = be_arr[winner];
  assign s_data_o = data_arr[winner];
  assign s_id_o   = {winner, id_arr[winner]};

  always_comb begin
    m_gnt_o = '0;
    if (handshake) m_gnt_o[winner] = 1'b1;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;
    if (handshake) begin
      locked_d = 1'b0;
      rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end else if (s_req) begin
      locked_d   = 1'b1;
      lock_idx_d = winner;
    end else if (locked_q && !m_req_i[lock_idx_q]) begin
      locked_d = 1'b0;
    end
    case ({handshake, resp_dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  // Responses tagged with an index no master owns match no lane and are dropped.
  logic [IDX_W-1:0]                resp_idx;
  logic [N_MASTERS-1:0]            r_valid_d;
  logic [N_MASTERS*ID_WIDTH-1:0]   r_id_d;
  logic [N_MASTERS*DATA_WIDTH-1:0] r_data_d;

  assign resp_idx = s_r_id_i[ID_WIDTH +: IDX_W];

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_resp
    assign r_valid_d[gi] = s_r_valid_i & (resp_idx == IDX_W'(gi)) & ~rst_i;
    assign r_id_d[gi*ID_WIDTH +: ID_WIDTH] =
      (resp_idx == IDX_W'(gi)) ? s_r_id_i[ID_WIDTH-1:0] : '0;
    assign r_data_d[gi*DATA_WIDTH +: DATA_WIDTH] = s_r_data_i;
  end

  if (RESP_REG != 0) begin : g_resp_reg
    logic [N_MASTERS-1:0]            r_valid_q;
    logic [N_MASTERS*ID_WIDTH-1:0]   r_id_q;
    logic [N_MASTERS*DATA_WIDTH-1:0] r_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_valid_q <= '0;
        r_id_q    <= '0;
        r_data_q  <= '0;
      end else begin
        r_valid_q <= r_valid_d;
        r_id_q    <= r_id_d;
        r_data_q  <= r_data_d;
      end
    end

    assign m_r_valid_o = r_valid_q;
    assign m_r_id_o    = r_id_q;
    assign m_r_data_o  = r_data_q;
  end else begin : g_resp_comb
    assign m_r_valid_o = r_valid_d;
    assign m_r_id_o    = r_id_d;
    assign m_r_data_o  = r_data_d;
  end

endmodule

// File: tb/tb_hwpe_ctrl_periph_mux_rr.sv
// Scoreboard bench: instance A (N=2, MAX=2, combinational responses) and
// instance B (N=3, MAX=4, registered responses) driven by directed vectors.
module tb_hwpe_ctrl_periph_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [31:0] add;
    logic [5:0]  sid;
    logic        we_n;
  } gexp_t;

  typedef struct packed {
    logic [2:0]  vld;
    logic [3:0]  id;
    logic [31:0] data;
  } rexp_t;

  gexp_t ga_q[$], gb_q[$];
  rexp_t ra_q[$], rb_q[$];
  gexp_t ge_a, ge_b;
  rexp_t re_a, re_b;

  // ---------------- instance A ----------------
  logic        rst_a;
  logic [1:0]  a_req, a_gnt, a_we_n, a_r_valid;
  logic [63:0] a_add, a_data, a_r_data;
  logic [7:0]  a_be, a_id, a_r_id;
  logic        a_s_req, a_s_gnt, a_s_we_n, a_s_r_valid;
  logic [31:0] a_s_add, a_s_data, a_s_r_data;
  logic [3:0]  a_s_be;
  logic [4:0]  a_s_id, a_s_r_id;

  hwpe_ctrl_periph_mux_rr #(
    .N_MASTERS(2), .ID_WIDTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .MAX_OUTSTANDING(2), .RESP_REG(0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .m_req_i(a_req), .m_gnt_o(a_gnt), .m_add_i(a_add), .m_we_n_i(a_we_n),
    .m_be_i(a_be), .m_data_i(a_data), .m_id_i(a_id),
    .m_r_data_o(a_r_data), .m_r_valid_o(a_r_valid), .m_r_id_o(a_r_id),
    .s_req_o(a_s_req), .s_gnt_i(a_s_gnt), .s_add_o(a_s_add), .s_we_n_o(a_s_we_n),
    .s_be_o(a_s_be), .s_data_o(a_s_data), .s_id_o(a_s_id),
    .s_r_data_i(a_s_r_data), .s_r_valid_i(a_s_r_valid), .s_r_id_i(a_s_r_id)
  );

  // ---------------- instance B ----------------
  logic        rst_b;
  logic [2:0]  b_req, b_gnt, b_we_n, b_r_valid;
  logic [95:0] b_add, b_data, b_r_data;
  logic [11:0] b_be, b_id, b_r_id;
  logic        b_s_req, b_s_gnt, b_s_we_n, b_s_r_valid;
  logic [31:0] b_s_add, b_s_data, b_s_r_data;
  logic [3:0]  b_s_be;
  logic [5:0]  b_s_id, b_s_r_id;

  hwpe_ctrl_periph_mux_rr #(
    .N_MASTERS(3), .ID_WIDTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .MAX_OUTSTANDING(4), .RESP_REG(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .m_req_i(b_req), .m_gnt_o(b_gnt), .m_add_i(b_add), .m_we_n_i(b_we_n),
    .m_be_i(b_be), .m_data_i(b_data), .m_id_i(b_id),
    .m_r_data_o(b_r_data), .m_r_valid_o(b_r_valid), .m_r_id_o(b_r_id),
    .s_req_o(b_s_req), .s_gnt_i(b_s_gnt), .s_add_o(b_s_add), .s_we_n_o(b_s_we_n),
    .s_be_o(b_s_be), .s_data_o(b_s_data), .s_id_o(b_s_id),
    .s_r_data_i(b_s_r_data), .s_r_valid_i(b_s_r_valid), .s_r_id_i(b_s_r_id)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_ga(input logic [2:0] g, input logic [31:0] ad, input logic [5:0] sid, input logic wn);
    ga_q.push_back('{gnt: g, add: ad, sid: sid, we_n: wn});
  endtask
  task automatic push_gb(input logic [2:0] g, input logic [31:0] ad, input logic [5:0] sid, input logic wn);
    gb_q.push_back('{gnt: g, add: ad, sid: sid, we_n: wn});
  endtask
  task automatic push_ra(input logic [2:0] v, input logic [3:0] id, input logic [31:0] d);
    ra_q.push_back('{vld: v, id: id, data: d});
  endtask
  task automatic push_rb(input logic [2:0] v, input logic [3:0] id, input logic [31:0] d);
    rb_q.push_back('{vld: v, id: id, data: d});
  endtask

  // Monitor A: a grant/request beat on every slave handshake, a response on any r_valid.
  always @(negedge clk) begin
    if (!rst_a) begin
      if (a_s_req && a_s_gnt) begin
        if (ga_q.size() == 0) unexp("a_grant", 64'(a_gnt));
        else begin
          ge_a = ga_q.pop_front();
          chk("a_gnt", 64'(a_gnt), 64'(ge_a.gnt[1:0]));
          chk("a_s_add", 64'(a_s_add), 64'(ge_a.add));
          chk("a_s_id", 64'(a_s_id), 64'(ge_a.sid[4:0]));
          chk("a_s_we_n", 64'(a_s_we_n), 64'(ge_a.we_n));
        end
      end else if (a_gnt != 2'b00) begin
        unexp("a_gnt_without_handshake", 64'(a_gnt));
      end
      if (a_r_valid != 2'b00) begin
        if (ra_q.size() == 0) unexp("a_r_valid", 64'(a_r_valid));
        else begin
          re_a = ra_q.pop_front();
          chk("a_r_valid", 64'(a_r_valid), 64'(re_a.vld[1:0]));
          for (int l = 0; l < 2; l++) begin
            if (re_a.vld[l]) chk("a_r_id", 64'(a_r_id[l*4 +: 4]), 64'(re_a.id));
            chk("a_r_data", 64'(a_r_data[l*32 +: 32]), 64'(re_a.data));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      if (b_s_req && b_s_gnt) begin
        if (gb_q.size() == 0) unexp("b_grant", 64'(b_gnt));
        else begin
          ge_b = gb_q.pop_front();
          chk("b_gnt", 64'(b_gnt), 64'(ge_b.gnt));
          chk("b_s_add", 64'(b_s_add), 64'(ge_b.add));
          chk("b_s_id", 64'(b_s_id), 64'(ge_b.sid));
          chk("b_s_we_n", 64'(b_s_we_n), 64'(ge_b.we_n));
        end
      end else if (b_gnt != 3'b000) begin
        unexp("b_gnt_without_handshake", 64'(b_gnt));
      end
      if (b_r_valid != 3'b000) begin
        if (rb_q.size() == 0) unexp("b_r_valid", 64'(b_r_valid));
        else begin
          re_b = rb_q.pop_front();
          chk("b_r_valid", 64'(b_r_valid), 64'(re_b.vld));
          for (int l = 0; l < 3; l++) begin
            if (re_b.vld[l]) chk("b_r_id", 64'(b_r_id[l*4 +: 4]), 64'(re_b.id));
            chk("b_r_data", 64'(b_r_data[l*32 +: 32]), 64'(re_b.data));
          end
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_req = '0; a_s_gnt = 1'b0; a_s_r_valid = 1'b0; a_s_r_id = '0; a_s_r_data = '0;
    a_add = {32'h2000_0004, 32'h1000_0000}; a_id = {4'hA, 4'h3};
    a_we_n = 2'b11; a_be = 8'hFF; a_data = {32'h0000_00B1, 32'h0000_00B0};
    b_req = '0; b_s_gnt = 1'b0; b_s_r_valid = 1'b0; b_s_r_id = '0; b_s_r_data = '0;
    b_add = {32'hA200_0000, 32'hA100_0000, 32'hA000_0000}; b_id = {4'h7, 4'h5, 4'h1};
    b_we_n = 3'b101; b_be = 12'hFFF; b_data = {32'hD2, 32'hD1, 32'hD0};

    // Held in reset with live requests: everything must stay quiet.
    step();
    a_req = 2'b11; a_s_gnt = 1'b1; a_s_r_valid = 1'b1; a_s_r_id = 5'h03;
    b_req = 3'b111; b_s_gnt = 1'b1; b_s_r_valid = 1'b1; b_s_r_id = 6'h01;
    mid();
    chk("a_rst_s_req", 64'(a_s_req), 64'd0);
    chk("a_rst_gnt", 64'(a_gnt), 64'd0);
    chk("a_rst_r_valid", 64'(a_r_valid), 64'd0);
    chk("b_rst_s_req", 64'(b_s_req), 64'd0);
    chk("b_rst_r_valid", 64'(b_r_valid), 64'd0);

    // ---- A: alternation, ID tagging, outstanding cap, stale response ----
    step(); rst_a = 1'b0; a_s_r_valid = 1'b0;
    push_ga(3'b001, 32'h1000_0000, 6'h03, 1'b1); mid();
    step(); a_s_r_valid = 1'b1; a_s_r_id = 5'h03; a_s_r_data = 32'h1111_0000;
    push_ga(3'b010, 32'h2000_0004, 6'h1A, 1'b1); push_ra(3'b001, 4'h3, 32'h1111_0000); mid();
    step(); a_s_r_valid = 1'b0;
    push_ga(3'b001, 32'h1000_0000, 6'h03, 1'b1); mid();
    step(); a_s_r_valid = 1'b1; a_s_r_id = 5'h1A; a_s_r_data = 32'hDEAD_BEEF;
    push_ra(3'b010, 4'hA, 32'hDEAD_BEEF); mid();
    chk("a_s_req_at_max", 64'(a_s_req), 64'd0);
    chk("a_gnt_at_max", 64'(a_gnt), 64'd0);
    step(); a_s_r_valid = 1'b0; a_s_gnt = 1'b0; mid();
    chk("a_s_req_unblocked", 64'(a_s_req), 64'd1);
    chk("a_s_add_rr_m1", 64'(a_s_add), 64'h2000_0004);
    step(); a_s_gnt = 1'b1;
    push_ga(3'b010, 32'h2000_0004, 6'h1A, 1'b1); mid();
    step(); a_req = 2'b00; a_s_gnt = 1'b0;
    a_s_r_valid = 1'b1; a_s_r_id = 5'h03; a_s_r_data = 32'h2222_2222;
    push_ra(3'b001, 4'h3, 32'h2222_2222); mid();
    step(); a_s_r_id = 5'h1A; a_s_r_data = 32'h3333_3333;
    push_ra(3'b010, 4'hA, 32'h3333_3333); mid();
    step(); a_s_r_id = 5'h03; a_s_r_data = 32'h4444_4444;
    push_ra(3'b001, 4'h3, 32'h4444_4444); mid();
    step(); a_s_r_valid = 1'b0; a_req = 2'b01; mid();
    chk("a_s_req_after_stale", 64'(a_s_req), 64'd1);
    step(); a_s_gnt = 1'b1;
    push_ga(3'b001, 32'h1000_0000, 6'h03, 1'b1); mid();
    step(); a_req = 2'b00; a_s_gnt = 1'b0; mid();

    // ---- B: locking, registered responses, drop, cap, async reset ----
    step(); rst_b = 1'b0; b_req = 3'b001; b_s_gnt = 1'b1; b_s_r_valid = 1'b0;
    push_gb(3'b001, 32'hA000_0000, 6'h01, 1'b1); mid();
    step(); b_s_gnt = 1'b0; mid();
    chk("b_lock_c1", 64'(b_s_add), 64'hA000_0000);
    step(); b_req = 3'b101; mid();
    chk("b_lock_c2", 64'(b_s_add), 64'hA000_0000);
    chk("b_lock_c2_id", 64'(b_s_id), 64'h01);
    step(); mid();
    chk("b_lock_c3", 64'(b_s_add), 64'hA000_0000);
    step(); b_s_gnt = 1'b1;
    push_gb(3'b001, 32'hA000_0000, 6'h01, 1'b1); mid();
    step();
    push_gb(3'b100, 32'hA200_0000, 6'h27, 1'b1); mid();
    step(); b_req = 3'b000; b_s_gnt = 1'b0;
    b_s_r_valid = 1'b1; b_s_r_id = 6'h01; b_s_r_data = 32'hCAFE_0001;
    push_rb(3'b001, 4'h1, 32'hCAFE_0001); mid();
    chk("b_resp_lat_t", 64'(b_r_valid), 64'd0);
    step(); b_s_r_valid = 1'b0; mid();
    chk("b_resp_lat_t1", 64'(b_r_valid), 64'b001);
    step(); b_req = 3'b010; b_s_gnt = 1'b1;
    b_s_r_valid = 1'b1; b_s_r_id = 6'h27; b_s_r_data = 32'hCAFE_0027;
    push_gb(3'b010, 32'hA100_0000, 6'h15, 1'b0); push_rb(3'b100, 4'h7, 32'hCAFE_0027); mid();
    chk("b_resp_lat_t2", 64'(b_r_valid), 64'd0);
    step(); b_req = 3'b000; b_s_gnt = 1'b0; b_s_r_id = 6'h3F; b_s_r_data = 32'hDEAD_0000; mid();
    step(); b_s_r_valid = 1'b0; b_req = 3'b001; b_s_gnt = 1'b1;
    push_gb(3'b001, 32'hA000_0000, 6'h01, 1'b1); mid();
    chk("b_bad_idx_dropped", 64'(b_r_valid), 64'd0);
    step(); b_req = 3'b011;
    push_gb(3'b010, 32'hA100_0000, 6'h15, 1'b0); mid();
    step();
    push_gb(3'b001, 32'hA000_0000, 6'h01, 1'b1); mid();
    step(); b_s_r_valid = 1'b1; b_s_r_id = 6'h15; b_s_r_data = 32'hCAFE_0015;
    push_rb(3'b010, 4'h5, 32'hCAFE_0015); mid();
    chk("b_s_req_at_max", 64'(b_s_req), 64'd0);
    step(); b_s_gnt = 1'b0; b_s_r_id = 6'h01; b_s_r_data = 32'hCAFE_0101; mid();
    chk("b_s_req_unblocked", 64'(b_s_req), 64'd1);
    chk("b_s_add_rr_m1", 64'(b_s_add), 64'hA100_0000);
    // Locked on m1 with two outstanding; reset lands mid-cycle.
    step(); rst_b = 1'b1; b_s_r_valid = 1'b0; b_s_gnt = 1'b1; #1;
    chk("b_async_rst_s_req", 64'(b_s_req), 64'd0);
    chk("b_async_rst_gnt", 64'(b_gnt), 64'd0);
    chk("b_async_rst_r_valid", 64'(b_r_valid), 64'd0);
    mid();
    step(); rst_b = 1'b0; b_s_gnt = 1'b0;
    b_s_r_valid = 1'b1; b_s_r_id = 6'h15; b_s_r_data = 32'hCAFE_0BAD;
    push_rb(3'b010, 4'h5, 32'hCAFE_0BAD); mid();
    chk("b_post_rst_winner", 64'(b_s_add), 64'hA000_0000);
    chk("b_post_rst_s_req", 64'(b_s_req), 64'd1);
    step(); b_s_r_valid = 1'b0; b_s_gnt = 1'b1;
    push_gb(3'b001, 32'hA000_0000, 6'h01, 1'b1); mid();
    step(); b_req = 3'b000; b_s_gnt = 1'b0; mid();
    step(); mid();

    chk("a_grants_left", 64'(ga_q.size()), 64'd0);
    chk("a_resps_left", 64'(ra_q.size()), 64'd0);
    chk("b_grants_left", 64'(gb_q.size()), 64'd0);
    chk("b_resps_left", 64'(rb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
